// File: rtl/veda_mem_pkg.sv
// Shared types and constants for the veda_mem bank.
// Holds the control FSM state type, request mode encodings and the
// storage index width helper used by the bank and its array.
package veda_mem_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  localparam logic MODE_WRITE = 1'b0;
  localparam logic MODE_READ  = 1'b1;

  // Index width for a storage array of 'depth' words (at least one bit).
  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/veda_mem_array.sv
// Word storage for veda_mem_bank.
// One synchronous write port with per-byte enables and one combinational
// read port. Contents are never reset; the owner clears them if needed.
// Ports:
//   clk      - write clock
//   we       - write enable (address must be in range)
//   waddr    - write word index
//   wdata    - write data
//   wbe      - byte enables, bit i covers wdata[8i+7:8i]
//   raddr    - read word index
//   rdata_c  - read data (combinational)
module veda_mem_array
  import veda_mem_pkg::*;
#(
  parameter  int unsigned DATA_W = 32,
  parameter  int unsigned DEPTH  = 512,
  localparam int unsigned IDX_W  = idx_width(DEPTH),
  localparam int unsigned BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [BE_W-1:0]   wbe,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata_c
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Byte-masked write
  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < BE_W; i++) begin
        if (wbe[i]) begin
          mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata_c = mem[raddr];

endmodule

// File: rtl/veda_mem_bank.sv
// Single-port memory bank with valid/ready request and response channels.
// Writes are byte-masked and silent; reads return one registered response
// per accepted request, held while the consumer stalls. Addresses at or
// above DEPTH are ignored on write and answer 0 with rsp_err on read.
// Optional feature (macro VEDA_MEM_CLEAR_EN): after reset a CLEAR sweep
// zeroes every word, one per cycle, with busy high; without it the bank is
// ready one edge after reset and the contents start undefined.
// Ports:
//   clk, rst                  - clock, async active-high reset
//   req_valid/req_ready       - request handshake
//   req_mode                  - 0 write, 1 read
//   req_addr/wdata/be         - request payload
//   rsp_valid/rsp_ready       - response handshake
//   rsp_rdata, rsp_err        - response payload
//   busy                      - clear sweep in progress
module veda_mem_bank
  import veda_mem_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DEPTH  = 512
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_mode,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                busy
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned IDX_W = idx_width(DEPTH);

  logic              addr_ok;
  logic              accept;
  logic              rdy;
  logic [IDX_W-1:0]  req_idx;

  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_wbe;
  logic [DATA_W-1:0] mem_rdata_c;

  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q,   rsp_err_d;

  assign addr_ok   = (32'(req_addr) < DEPTH);
  assign req_idx   = IDX_W'(req_addr);
  // A stalled response blocks new requests so it cannot be overwritten
  assign req_ready = rdy && !(rsp_valid_q && !rsp_ready);
  assign accept    = req_valid && req_ready;

`ifdef VEDA_MEM_CLEAR_EN
  state_e           state_q,   state_d;
  logic [IDX_W-1:0] clr_cnt_q, clr_cnt_d;

  // State and sweep counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Next state and write-port steering: sweep owns the port in CLEAR
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    mem_we    = 1'b0;
    mem_waddr = req_idx;
    mem_wdata = req_wdata;
    mem_wbe   = req_be;
    case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_q;
        mem_wdata = '0;
        mem_wbe   = '1;
        if (clr_cnt_q == IDX_W'(DEPTH - 1)) begin
          state_d = READY;
        end else begin
          clr_cnt_d = clr_cnt_q + IDX_W'(1);
        end
      end
      READY: begin
        mem_we = accept && (req_mode == MODE_WRITE) && addr_ok;
      end
    endcase
  end

  assign rdy  = (state_q == READY);
  assign busy = (state_q == CLEAR);
`else
  logic rdy_q, rdy_d;

  // Holds off requests until the first edge after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_q <= 1'b0;
    end else begin
      rdy_q <= rdy_d;
    end
  end

  always_comb begin
    rdy_d     = 1'b1;
    mem_we    = accept && (req_mode == MODE_WRITE) && addr_ok;
    mem_waddr = req_idx;
    mem_wdata = req_wdata;
    mem_wbe   = req_be;
  end

  assign rdy  = rdy_q;
  assign busy = 1'b0;
`endif

  veda_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk     (clk),
    .we      (mem_we),
    .waddr   (mem_waddr),
    .wdata   (mem_wdata),
    .wbe     (mem_wbe),
    .raddr   (req_idx),
    .rdata_c (mem_rdata_c)
  );

  // Response register: load on read accept, hold while stalled
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    if (accept && (req_mode == MODE_READ)) begin
      rsp_valid_d = 1'b1;
      rsp_rdata_d = addr_ok ? mem_rdata_c : '0;
      rsp_err_d   = !addr_ok;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: doc/veda_mem_bank.md
VEDA_MEM_BANK -- requirements
Module: veda_mem_bank

Interface
REQ-001 Parameter DATA_W, default 32: data word width, multiple of 8.
REQ-002 Parameter ADDR_W, default 9: address width.
REQ-003 Parameter DEPTH, default 512: implemented words, 1 <= DEPTH <= 2**ADDR_W.
REQ-004 clk  input  1: single clock; all state SHALL change on its rising edge.
REQ-005 rst  input  1: asynchronous, active-high reset.
REQ-006 req_valid  input  1: request present.
REQ-007 req_ready  output  1: request accepted this cycle when high with req_valid.
REQ-008 req_mode  input  1: 0 = write, 1 = read.
REQ-009 req_addr  input  ADDR_W: word address.
REQ-010 req_wdata  input  DATA_W: write data.
REQ-011 req_be  input  DATA_W/8: byte enables for writes; bit i covers bits 8i+7..8i.
REQ-012 rsp_valid  output  1: read response valid.
REQ-013 rsp_ready  input  1: consumer takes response when high with rsp_valid.
REQ-014 rsp_rdata  output  DATA_W: read data.
REQ-015 rsp_err  output  1: response addressed word >= DEPTH.
REQ-016 busy  output  1: clear sweep in progress.

Function
REQ-017 Accept SHALL occur on a rising edge with req_valid && req_ready; a single port, one request per cycle.
REQ-018 req_ready SHALL be 1 iff state is READY and not (rsp_valid && !rsp_ready).
REQ-019 Accepted write SHALL update only the bytes with req_be set; writes produce no response.
REQ-020 Write with req_be all-zero SHALL leave memory unchanged.
REQ-021 Accepted read SHALL raise rsp_valid on the following edge with rsp_rdata = mem[req_addr].
REQ-022 rsp_valid, rsp_rdata and rsp_err SHALL hold stable while rsp_valid && !rsp_ready.
REQ-023 Response taken with a new read accepted in the same cycle SHALL give back-to-back rsp_valid, one read per cycle.
REQ-024 Response taken with no new read SHALL clear rsp_valid next edge.
REQ-025 Read accepted the cycle after a write to the same address SHALL return the newly written data.
REQ-026 Address >= DEPTH: write ignored; read returns rsp_rdata = 0 with rsp_err = 1.
REQ-027 FSM states: CLEAR (sweep) and READY; CLEAR -> READY after writing word DEPTH-1; READY has no exit except rst.

Reset
REQ-028 While rst is high: rsp_valid = 0, rsp_err = 0, rsp_rdata = 0, req_ready = 0, sweep counter = 0.
REQ-029 With sweep compiled in, reset SHALL enter CLEAR with busy = 1; without, it SHALL enter READY with busy = 0.
REQ-030 rst asserted mid-sweep or mid-response SHALL abort it; a pending response is discarded and the sweep restarts from word 0.
REQ-031 Memory contents SHALL NOT be reset directly; only the sweep clears them.

Configuration
REQ-032 Macro VEDA_MEM_CLEAR_EN defined: CLEAR SHALL write zero to words 0..DEPTH-1, one per cycle, over exactly DEPTH cycles after rst falls, with busy = 1 and req_ready = 0 throughout.
REQ-033 VEDA_MEM_CLEAR_EN undefined: no CLEAR state and no counter; busy is tied to 0; contents after reset are undefined; READY is entered on the first edge after rst falls.

Structure
REQ-034 Package veda_mem_pkg SHALL hold the FSM state type (CLEAR, READY) and the mode constants MODE_WRITE = 0 and MODE_READ = 1.
REQ-035 Storage SHALL be the sub-module veda_mem_array: one synchronous write port with byte enables and one read port; the control FSM and response register live in veda_mem_bank.

Verification
REQ-036 VEDA_MEM_CLEAR_EN defined, DEPTH = 512, rst pulse -> busy = 1 for exactly 512 cycles, then req_ready = 1; a read of address 5 returns 0.
REQ-037 Write addr 5 data 0x00000009 be 0xF, then read addr 5 with rsp_ready = 1 -> rsp_valid one cycle later, rsp_rdata = 0x00000009, rsp_err = 0.
REQ-038 Write addr 1 data 0xAABBCCDD be 0xF, then write addr 1 data 0x11223344 be 0x5, then read addr 1 -> rsp_rdata = 0xAA22CC44.
REQ-039 Read addr 5 with rsp_ready = 0 for 3 cycles -> rsp_valid and rsp_rdata held stable, req_ready = 0 during the stall; response taken on the cycle rsp_ready = 1.
REQ-040 DEPTH = 300, read addr 400 -> rsp_rdata = 0, rsp_err = 1; write to addr 400 leaves addr 144 unchanged.
REQ-041 rst asserted 100 cycles into the sweep and while a response is pending -> rsp_valid drops at once; the sweep restarts and busy lasts DEPTH cycles after rst falls.
